// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive-side frame controller.
package uart_pkg;

   typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, HOLD} rx_frm_state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer for one frame: MAX_LEN x 8 simple dual-port RAM, registered read.
module uart_frame_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // read port: one cycle latency, cleared only so the output is defined out of reset
   always_ff @(posedge clk) begin
      if (rst) rd_data <= 8'h00;
      else     rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frames UART bytes (SYNC, LEN, payload, XOR checksum) and hands good frames to the host.
// Optional inter-byte timeout is built when RX_FRAME_TIMEOUT_EN is defined.
module uart_rx_frame_ctrl
   import uart_pkg::*;
#(
   parameter int          MAX_LEN        = 16,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int          TIMEOUT_CYCLES = 208000,
   localparam int         AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          rx_done,
   input  logic [7:0]    rx_data,
   output logic          frm_valid,
   input  logic          frm_ready,
   output logic [7:0]    frm_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          err_chksum,
   output logic          err_len,
   output logic          err_overrun,
   output logic          err_timeout
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_param_range
      $error("uart_rx_frame_ctrl: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 2");
   end

   rx_frm_state_t state;
   logic [7:0]    acc;
   logic [7:0]    idx;
   logic          wr_en;

   assign wr_en = rx_done && (state == PAYLOAD);

   uart_frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (idx[AW-1:0]),
      .wr_data (rx_data),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

`ifdef RX_FRAME_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] to_cnt;
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= HUNT;
         frm_valid   <= 1'b0;
         frm_len     <= 8'h00;
         acc         <= 8'h00;
         idx         <= 8'h00;
         err_chksum  <= 1'b0;
         err_len     <= 1'b0;
         err_overrun <= 1'b0;
`ifdef RX_FRAME_TIMEOUT_EN
         err_timeout <= 1'b0;
         to_cnt      <= '0;
`endif
      end else begin
         err_chksum  <= 1'b0;
         err_len     <= 1'b0;
         err_overrun <= 1'b0;
         if (rx_done) begin
            case (state)
               HUNT: if (rx_data == SYNC_BYTE) state <= LEN;
               LEN: begin
                  frm_len <= rx_data;
                  acc     <= rx_data;
                  idx     <= 8'h00;
                  if (rx_data > MAX_LEN_B) begin
                     err_len <= 1'b1;
                     state   <= HUNT;
                  end else if (rx_data == 8'h00) begin
                     state <= CHECK;
                  end else begin
                     state <= PAYLOAD;
                  end
               end
               PAYLOAD: begin
                  acc <= acc ^ rx_data;
                  if (idx == frm_len - 8'd1) state <= CHECK;
                  else                       idx   <= idx + 8'd1;
               end
               CHECK: begin
                  if (rx_data == acc) begin
                     state     <= HOLD;
                     frm_valid <= 1'b1;
                  end else begin
                     err_chksum <= 1'b1;
                     state      <= HUNT;
                  end
               end
               HOLD:    err_overrun <= 1'b1;
               default: state <= HUNT;
            endcase
         end
         // release is independent of a colliding byte, which is still flagged as overrun
         if (state == HOLD && frm_valid && frm_ready) begin
            frm_valid <= 1'b0;
            state     <= HUNT;
         end
`ifdef RX_FRAME_TIMEOUT_EN
         err_timeout <= 1'b0;
         if (rx_done || state == HUNT || state == HOLD) begin
            to_cnt <= '0;
         end else if (to_cnt == TO_LAST) begin
            to_cnt      <= '0;
            err_timeout <= 1'b1;
            state       <= HUNT;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl (MAX_LEN=16, TIMEOUT_CYCLES=100).
module tb_uart_rx_frame_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       frm_valid;
   logic       frm_ready = 1'b0;
   logic [7:0] frm_len;
   logic [3:0] rd_addr = 4'h0;
   logic [7:0] rd_data;
   logic       err_chksum, err_len, err_overrun, err_timeout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   uart_rx_frame_ctrl #(
      .MAX_LEN        (16),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_done     (rx_done),
      .rx_data     (rx_data),
      .frm_valid   (frm_valid),
      .frm_ready   (frm_ready),
      .frm_len     (frm_len),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .err_chksum  (err_chksum),
      .err_len     (err_len),
      .err_overrun (err_overrun),
      .err_timeout (err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick(1);
      rx_done = 1'b0;
   endtask

   task automatic read_chk(input string tag, input logic [3:0] a, input logic [7:0] exp);
      rd_addr = a;
      tick(1);
      chk(tag, {24'h0, rd_data}, {24'h0, exp});
   endtask

   task automatic release_frame(input string tag);
      frm_ready = 1'b1;
      tick(1);
      frm_ready = 1'b0;
      chk(tag, {31'h0, frm_valid}, 32'h0);
   endtask

   function automatic logic [31:0] errs();
      return {28'h0, err_chksum, err_len, err_overrun, err_timeout};
   endfunction

   initial begin
      tick(2);
      chk("reset_valid", {31'h0, frm_valid}, 32'h0);
      chk("reset_len",   {24'h0, frm_len},   32'h0);
      chk("reset_rd",    {24'h0, rd_data},   32'h0);
      chk("reset_errs",  errs(),             32'h0);
      rst = 1'b0;
      tick(1);

      // good 3-byte frame
      send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
      chk("t1_not_yet_valid", {31'h0, frm_valid}, 32'h0);
      send(8'h03);
      chk("t1_valid", {31'h0, frm_valid}, 32'h1);
      chk("t1_len",   {24'h0, frm_len},   32'h3);
      read_chk("t1_rd0", 4'd0, 8'h11);
      read_chk("t1_rd1", 4'd1, 8'h22);
      read_chk("t1_rd2", 4'd2, 8'h33);
      chk("t1_still_valid", {31'h0, frm_valid}, 32'h1);
      release_frame("t1_release");

      // bad checksum, then a good frame (02^AA^BB = 13)
      send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h00);
      chk("t2_chksum_pulse", errs(), 32'h8);
      chk("t2_no_valid", {31'h0, frm_valid}, 32'h0);
      tick(1);
      chk("t2_pulse_one_cycle", errs(), 32'h0);
      send(8'hA5); send(8'h02); send(8'hAA); send(8'hBB); send(8'h13);
      chk("t2_good_valid", {31'h0, frm_valid}, 32'h1);
      chk("t2_good_len",   {24'h0, frm_len},   32'h2);
      read_chk("t2_rd1", 4'd1, 8'hBB);
      release_frame("t2_release");

      // junk before sync, zero-length frame
      send(8'h00); send(8'hFF);
      chk("t3_junk_ignored", {31'h0, frm_valid} | errs(), 32'h0);
      send(8'hA5); send(8'h00); send(8'h00);
      chk("t3_valid", {31'h0, frm_valid}, 32'h1);
      chk("t3_len",   {24'h0, frm_len},   32'h0);
      release_frame("t3_release");

      // sync value inside a frame is data (02^A5^A5 = 02)
      send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5); send(8'h02);
      chk("t3b_sync_as_data_valid", {31'h0, frm_valid}, 32'h1);
      read_chk("t3b_rd0", 4'd0, 8'hA5);
      release_frame("t3b_release");

      // overlong length, then overrun while holding (01^5A = 5B)
      send(8'hA5); send(8'h11);
      chk("t4_len_pulse", errs(), 32'h4);
      tick(1);
      chk("t4_len_one_cycle", errs(), 32'h0);
      send(8'hA5); send(8'h10);
      chk("t4_max_len_ok", errs(), 32'h0);
      tick(1);
      rst = 1'b1; tick(1); rst = 1'b0;
      send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
      chk("t4_valid", {31'h0, frm_valid}, 32'h1);
      send(8'h77);
      chk("t4_overrun_pulse", errs(), 32'h2);
      chk("t4_still_valid", {31'h0, frm_valid}, 32'h1);
      chk("t4_len_intact", {24'h0, frm_len}, 32'h1);
      read_chk("t4_data_intact", 4'd0, 8'h5A);
      chk("t4_overrun_one_cycle", errs(), 32'h0);
      frm_ready = 1'b1;
      send(8'h66);
      frm_ready = 1'b0;
      chk("t4_handshake_overrun", errs(), 32'h2);
      chk("t4_handshake_release", {31'h0, frm_valid}, 32'h0);

`ifdef RX_FRAME_TIMEOUT_EN
      send(8'hA5); send(8'h02); send(8'hAA);
      tick(99);
      chk("t5_no_early_timeout", errs(), 32'h0);
      tick(1);
      chk("t5_timeout_pulse", errs(), 32'h1);
      tick(1);
      chk("t5_timeout_one_cycle", errs(), 32'h0);
      send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
      chk("t5_after_timeout_valid", {31'h0, frm_valid}, 32'h1);
      release_frame("t5_release");
`else
      send(8'hA5); send(8'h02); send(8'hAA);
      tick(150);
      chk("t5_no_timeout", errs(), 32'h0);
      send(8'hBB); send(8'h13);
      chk("t5_stalled_frame_valid", {31'h0, frm_valid}, 32'h1);
      release_frame("t5_release");
`endif

      // reset mid-payload, then a fresh frame
      rd_addr = 4'd0;
      send(8'hA5); send(8'h03); send(8'h11);
      tick(1);
      chk("t6_rd_before_reset", {24'h0, rd_data}, 32'h11);
      rst = 1'b1;
      tick(1);
      chk("t6_reset_valid", {31'h0, frm_valid}, 32'h0);
      chk("t6_reset_len",   {24'h0, frm_len},   32'h0);
      chk("t6_reset_rd",    {24'h0, rd_data},   32'h0);
      chk("t6_reset_errs",  errs(),             32'h0);
      rst = 1'b0;
      send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
      chk("t6_fresh_valid", {31'h0, frm_valid}, 32'h1);
      chk("t6_fresh_len",   {24'h0, frm_len},   32'h1);
      read_chk("t6_fresh_rd0", 4'd0, 8'h7E);
      release_frame("t6_release");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
